// File: rtl/whack_pkg.sv
// rtl/whack_pkg.sv - shared state encoding and default timing for the mole round controller
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        UP   = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam int DEF_HOLE_W     = 3;
    localparam int DEF_UP_TICKS   = 500;
    localparam int DEF_GAP_TICKS  = 200;
    localparam int DEF_MAX_MISSES = 5;
    localparam int DEF_SCORE_W    = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mole_round_ctrl_if.sv
// rtl/mole_round_ctrl_if.sv - game-side signal bundle of the mole round controller
interface mole_round_ctrl_if #(
    parameter int HOLE_W  = 3,
    parameter int SCORE_W = 8
);
    logic                 start;
    logic                 tick;
    logic [3:0]           rnd;
    logic [2**HOLE_W-1:0] btn;
    logic [2**HOLE_W-1:0] mole;
    logic [SCORE_W-1:0]   score;
    logic [3:0]           misses;
    logic                 hit_pulse;
    logic                 miss_pulse;
    logic                 game_over;

    modport master (
        output start, tick, rnd, btn,
        input  mole, score, misses, hit_pulse, miss_pulse, game_over
    );

    modport slave (
        input  start, tick, rnd, btn,
        output mole, score, misses, hit_pulse, miss_pulse, game_over
    );
endinterface

// File: rtl/mole_tick_timer.sv
// rtl/mole_tick_timer.sv - tick-paced terminal-count timer with per-state limit
module mole_tick_timer #(
    parameter int CNT_W = 9
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           restart,
    input  logic           tick,
    input  logic [CNT_W:0] limit,
    output logic           done
);
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W:0]   LIMIT_ONE = 1;

    logic [CNT_W-1:0] cnt;

    // The limit is one bit wider than the counter so that a limit equal to
    // 2**CNT_W is still representable; the counter itself never reaches it.
    assign done = tick && ({1'b0, cnt} == (limit - LIMIT_ONE));

    // Count ticks, wrapping on terminal count; restart pins the count at zero.
    always_ff @(posedge clk) begin
        if (clr || restart) begin
            cnt <= '0;
        end else if (done) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + CNT_ONE;
        end
    end
endmodule

// File: rtl/mole_round_ctrl.sv
// rtl/mole_round_ctrl.sv - whack-a-mole round FSM; optional MOLE_WRONG_PENALTY_EN makes wrong presses count as misses
module mole_round_ctrl
    import whack_pkg::*;
#(
    parameter int HOLE_W     = DEF_HOLE_W,
    parameter int UP_TICKS   = DEF_UP_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS,
    parameter int MAX_MISSES = DEF_MAX_MISSES,
    parameter int SCORE_W    = DEF_SCORE_W
) (
    input  logic           clk,
    input  logic           clr,
    mole_round_ctrl_if.slave bus
);
    localparam int NUM_HOLES = 2**HOLE_W;
    localparam int MAX_TICKS = max_int(UP_TICKS, GAP_TICKS);
    localparam int CNT_W     = ($clog2(MAX_TICKS) < 1) ? 1 : $clog2(MAX_TICKS);

    localparam logic [CNT_W:0]         UP_LIMIT   = (CNT_W+1)'(UP_TICKS);
    localparam logic [CNT_W:0]         GAP_LIMIT  = (CNT_W+1)'(GAP_TICKS);
    localparam logic [HOLE_W-1:0]      HOLE_ONE   = 1;
    localparam logic [SCORE_W-1:0]     SCORE_ONE  = 1;
    localparam logic [NUM_HOLES-1:0]   HOLE_BIT0  = 1;
    localparam logic [3:0]             MISS_LIMIT = 4'(MAX_MISSES);

    state_t                 state_q, state_n;
    logic [NUM_HOLES-1:0]   mole_q, mole_n;
    logic [SCORE_W-1:0]     score_q, score_n;
    logic [3:0]             misses_q, misses_n;
    logic [HOLE_W-1:0]      prev_q, prev_n;
    logic                   hit_q, hit_n;
    logic                   miss_q, miss_n;
    logic                   over_q, over_n;

    logic [HOLE_W-1:0]      spawn;
    logic [CNT_W:0]         limit;
    logic                   restart;
    logic                   done;
    logic                   hit;
    logic                   wrong;
    logic                   miss;

    mole_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .tick    (bus.tick),
        .limit   (limit),
        .done    (done)
    );

    // Next state and next registered outputs; prev_q doubles as the lit hole while UP.
    always_comb begin
        state_n  = state_q;
        mole_n   = mole_q;
        score_n  = score_q;
        misses_n = misses_q;
        prev_n   = prev_q;
        hit_n    = 1'b0;
        miss_n   = 1'b0;
        limit    = GAP_LIMIT;
        hit      = 1'b0;
        wrong    = 1'b0;
        miss     = 1'b0;
        spawn    = bus.rnd[HOLE_W-1:0];
        if (spawn == prev_q) begin
            spawn = spawn + HOLE_ONE;
        end

        case (state_q)
            IDLE: begin
                score_n  = '0;
                misses_n = '0;
                prev_n   = '0;
                mole_n   = '0;
                if (bus.start) begin
                    state_n = GAP;
                end
            end
            GAP: begin
                limit = GAP_LIMIT;
                if (done) begin
                    state_n = UP;
                    prev_n  = spawn;
                    mole_n  = HOLE_BIT0 << spawn;
                end
            end
            UP: begin
                limit = UP_LIMIT;
                hit   = bus.btn[prev_q];
`ifdef MOLE_WRONG_PENALTY_EN
                wrong = |(bus.btn & ~mole_q);
`else
                wrong = 1'b0;
`endif
                miss  = !hit && (done || wrong);
                if (hit) begin
                    state_n = GAP;
                    mole_n  = '0;
                    hit_n   = 1'b1;
                    if (score_q != '1) begin
                        score_n = score_q + SCORE_ONE;
                    end
                end else if (miss) begin
                    mole_n   = '0;
                    miss_n   = 1'b1;
                    misses_n = misses_q + 4'd1;
                    state_n  = (misses_q + 4'd1 == MISS_LIMIT) ? OVER : GAP;
                end
            end
            OVER: begin
                mole_n = '0;
                if (bus.start) begin
                    state_n  = GAP;
                    score_n  = '0;
                    misses_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // The tick count starts from zero on every state entry and idles at zero.
        restart = (state_n != state_q) || (state_q == IDLE) || (state_q == OVER);
        over_n  = (state_n == OVER);
    end

    // State and output registers; clr discards any round in progress.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= IDLE;
            mole_q   <= '0;
            score_q  <= '0;
            misses_q <= '0;
            prev_q   <= '0;
            hit_q    <= 1'b0;
            miss_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            mole_q   <= mole_n;
            score_q  <= score_n;
            misses_q <= misses_n;
            prev_q   <= prev_n;
            hit_q    <= hit_n;
            miss_q   <= miss_n;
            over_q   <= over_n;
        end
    end

    assign bus.mole       = mole_q;
    assign bus.score      = score_q;
    assign bus.misses     = misses_q;
    assign bus.hit_pulse  = hit_q;
    assign bus.miss_pulse = miss_q;
    assign bus.game_over  = over_q;
endmodule
